// File: rtl/ibus_initiator.sv
// ibus_initiator: CPU-side initiator for the SH7604 internal peripheral bus.
// Converts single byte/word/long CPU requests into IBUS cycles. It generates
// big-endian byte lanes, replicates write data across lanes and extracts read
// data. Misaligned, reserved-size and unmapped accesses are reported as errors.
// Optional feature macro: IBUS_TIMEOUT_EN. When it is defined, an access is
// aborted with an error once BUSY has been held for TIMEOUT WAIT edges.
module ibus_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_ACK,
  output logic        CPU_ERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_cpu_do, w_cpu_do_nx;
  logic        r_ack, w_ack_nx;
  logic        r_err, w_err_nx;
  logic [31:0] r_ibus_a, w_ibus_a_nx;
  logic [31:0] r_ibus_do, w_ibus_do_nx;
  logic [3:0]  r_ibus_ba, w_ibus_ba_nx;
  logic        r_ibus_we, w_ibus_we_nx;
  logic        r_ibus_req, w_ibus_req_nx;

  logic        w_misalign;
  logic [3:0]  w_ba;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_unused;

`ifdef IBUS_TIMEOUT_EN
  logic [7:0]  r_cnt, w_cnt_nx;
  assign w_unused = CE_F;
`else
  // CE_F and TIMEOUT have no function without the timeout counter.
  assign w_unused = ^{CE_F, 8'(TIMEOUT)};
`endif

  // Decode request alignment, byte lanes and replicated write data.
  always_comb begin
    w_misalign = (CPU_SZ == 2'd3) ||
                 ((CPU_SZ == 2'd1) && CPU_A[0]) ||
                 ((CPU_SZ == 2'd2) && (CPU_A[1:0] != 2'd0));
    w_ba    = 4'b1111;
    w_wdata = CPU_DI;
    case (CPU_SZ)
      2'd0: begin
        w_ba    = 4'b1000 >> CPU_A[1:0];
        w_wdata = {4{CPU_DI[7:0]}};
      end
      2'd1: begin
        w_ba    = CPU_A[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{CPU_DI[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the read lane(s) selected by the active byte enables, zero-extended.
  always_comb begin
    w_rdata = '0;
    case (r_ibus_ba)
      4'b1111: w_rdata = IBUS_DI;
      4'b1100: w_rdata = {16'h0, IBUS_DI[31:16]};
      4'b0011: w_rdata = {16'h0, IBUS_DI[15:0]};
      4'b1000: w_rdata = {24'h0, IBUS_DI[31:24]};
      4'b0100: w_rdata = {24'h0, IBUS_DI[23:16]};
      4'b0010: w_rdata = {24'h0, IBUS_DI[15:8]};
      4'b0001: w_rdata = {24'h0, IBUS_DI[7:0]};
      default: w_rdata = '0;
    endcase
  end

  // Next-state and next-output logic; everything advances only on CE_R.
  always_comb begin
    w_state_nx    = r_state;
    w_cpu_do_nx   = r_cpu_do;
    w_ack_nx      = r_ack;
    w_err_nx      = r_err;
    w_ibus_a_nx   = r_ibus_a;
    w_ibus_do_nx  = r_ibus_do;
    w_ibus_ba_nx  = r_ibus_ba;
    w_ibus_we_nx  = r_ibus_we;
    w_ibus_req_nx = r_ibus_req;
`ifdef IBUS_TIMEOUT_EN
    w_cnt_nx      = r_cnt;
`endif
    if (CE_R) begin
      w_ack_nx = 1'b0;
      w_err_nx = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (CPU_REQ) begin
            if (w_misalign) begin
              w_ack_nx    = 1'b1;
              w_err_nx    = 1'b1;
              w_cpu_do_nx = '0;
            end else begin
              w_ibus_a_nx   = CPU_A;
              w_ibus_we_nx  = CPU_WE;
              w_ibus_req_nx = 1'b1;
              w_ibus_ba_nx  = w_ba;
              w_ibus_do_nx  = w_wdata;
              w_state_nx    = S_REQ;
`ifdef IBUS_TIMEOUT_EN
              w_cnt_nx      = '0;
`endif
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (!IBUS_ACT) begin
            w_ibus_req_nx = 1'b0;
            w_ibus_we_nx  = 1'b0;
            w_ack_nx      = 1'b1;
            w_err_nx      = 1'b1;
            w_cpu_do_nx   = '0;
            w_state_nx    = S_IDLE;
          end else if (IBUS_BUSY) begin
`ifdef IBUS_TIMEOUT_EN
            // The edge that would bring the count to TIMEOUT aborts instead.
            if ((r_state == S_WAIT) && (r_cnt == 8'(TIMEOUT - 1))) begin
              w_ibus_req_nx = 1'b0;
              w_ibus_we_nx  = 1'b0;
              w_ack_nx      = 1'b1;
              w_err_nx      = 1'b1;
              w_cpu_do_nx   = '0;
              w_state_nx    = S_IDLE;
            end else begin
              if (r_state == S_WAIT) w_cnt_nx = r_cnt + 8'd1;
              w_state_nx = S_WAIT;
            end
`else
            w_state_nx = S_WAIT;
`endif
          end else begin
            w_ibus_req_nx = 1'b0;
            w_ibus_we_nx  = 1'b0;
            w_ack_nx      = 1'b1;
            if (!r_ibus_we) w_cpu_do_nx = w_rdata;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cpu_do   <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_ibus_a   <= '0;
      r_ibus_do  <= '0;
      r_ibus_ba  <= '0;
      r_ibus_we  <= 1'b0;
      r_ibus_req <= 1'b0;
`ifdef IBUS_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cpu_do   <= w_cpu_do_nx;
      r_ack      <= w_ack_nx;
      r_err      <= w_err_nx;
      r_ibus_a   <= w_ibus_a_nx;
      r_ibus_do  <= w_ibus_do_nx;
      r_ibus_ba  <= w_ibus_ba_nx;
      r_ibus_we  <= w_ibus_we_nx;
      r_ibus_req <= w_ibus_req_nx;
`ifdef IBUS_TIMEOUT_EN
      r_cnt      <= w_cnt_nx;
`endif
    end
  end

  assign CPU_DO   = r_cpu_do;
  assign CPU_ACK  = r_ack;
  assign CPU_ERR  = r_err;
  assign IBUS_A   = r_ibus_a;
  assign IBUS_DO  = r_ibus_do;
  assign IBUS_BA  = r_ibus_ba;
  assign IBUS_WE  = r_ibus_we;
  assign IBUS_REQ = r_ibus_req;

endmodule
